matrix_stack: RTL and testbench

Holds the modelview and projection matrix stacks for the transform stage and serves the top-of-stack matrix to `matrix_mul` as four 128-bit row words. It sits both upstream and downstream of `matrix_mul`: its peek outputs feed the multiplier's `matrix_peek_*` inputs, and it absorbs the multiplier's `matrix_write_en` / `matrix_write_out_*` result into the top of the selected stack. It also executes the push, pop and load-identity stack commands issued by the command decoder.

---
 rtl/matrix_stack.sv | 216 +++++++++++++++++++++
 tb/tb_matrix_stack.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stack.sv
// Modelview / projection matrix stacks for the transform stage.
// Serves the selected top-of-stack to matrix_mul and absorbs its result rows.
module matrix_stack #(
  parameter int MV_DEPTH   = 32,
  parameter int PROJ_DEPTH = 2,
  parameter int PTR_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               matrix_mode_in,
  input  logic               push,
  input  logic               pop,
  input  logic               load_identity,
  input  logic               matrix_write_en,
  input  logic               matrix_mode_wr,
  input  logic [127:0]       matrix_write_in_0,
  input  logic [127:0]       matrix_write_in_1,
  input  logic [127:0]       matrix_write_in_2,
  input  logic [127:0]       matrix_write_in_3,
  output logic [127:0]       matrix_peek_0,
  output logic [127:0]       matrix_peek_1,
  output logic [127:0]       matrix_peek_2,
  output logic [127:0]       matrix_peek_3,
  output logic [PTR_W-1:0]   depth_mv,
  output logic [PTR_W-1:0]   depth_proj,
  output logic               overflow,
  output logic               underflow,
  output logic               cmd_dropped,
  input  logic               err_clear
);

  localparam logic [127:0] ID_R0 = {32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000};
  localparam logic [127:0] ID_R1 = {32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000};
  localparam logic [127:0] ID_R2 = {32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000};
  localparam logic [127:0] ID_R3 = {32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000};
  localparam logic [511:0] IDENT = {ID_R0, ID_R1, ID_R2, ID_R3};

  localparam int MV_AW   = (MV_DEPTH > 1) ? $clog2(MV_DEPTH) : 1;
  localparam int PROJ_AW = (PROJ_DEPTH > 1) ? $clog2(PROJ_DEPTH) : 1;
  localparam logic [PTR_W-1:0] MV_FULL   = PTR_W'(MV_DEPTH);
  localparam logic [PTR_W-1:0] PROJ_FULL = PTR_W'(PROJ_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // Tops hold row 0 in the most significant 128 bits.
  logic [511:0]     r_top_mv;
  logic [511:0]     r_top_proj;
  logic [511:0]     r_sav_mv   [MV_DEPTH];
  logic [511:0]     r_sav_proj [PROJ_DEPTH];
  logic [PTR_W-1:0] r_depth_mv;
  logic [PTR_W-1:0] r_depth_proj;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_cmd_dropped;

  logic [511:0]     w_wr_data;
  logic             w_wr_mv;
  logic             w_wr_proj;
  logic             w_cmd_any;
  logic             w_cmd_multi;
  logic             w_cmd_blocked;
  logic             w_cmd_ok;
  logic             w_do_pop;
  logic             w_do_push;
  logic             w_do_li;
  logic             w_mv_full;
  logic             w_mv_empty;
  logic             w_proj_full;
  logic             w_proj_empty;
  logic             w_mv_push_ok;
  logic             w_mv_pop_ok;
  logic             w_mv_li;
  logic             w_proj_push_ok;
  logic             w_proj_pop_ok;
  logic             w_proj_li;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic [MV_AW-1:0]   w_mv_wr_idx;
  logic [MV_AW-1:0]   w_mv_rd_idx;
  logic [PROJ_AW-1:0] w_proj_wr_idx;
  logic [PROJ_AW-1:0] w_proj_rd_idx;
  logic [511:0]     w_mv_top_nxt;
  logic [511:0]     w_proj_top_nxt;
  logic [PTR_W-1:0] w_mv_depth_nxt;
  logic [PTR_W-1:0] w_proj_depth_nxt;
  logic [511:0]     w_peek;

  assign w_wr_data = {matrix_write_in_0, matrix_write_in_1, matrix_write_in_2, matrix_write_in_3};
  assign w_wr_mv   = matrix_write_en & ~matrix_mode_wr;
  assign w_wr_proj = matrix_write_en & matrix_mode_wr;

  // A write to the commanded stack always beats the command; pop > push > load_identity.
  assign w_cmd_any     = push | pop | load_identity;
  assign w_cmd_multi   = (push & pop) | (push & load_identity) | (pop & load_identity);
  assign w_cmd_blocked = w_cmd_any & matrix_write_en & (matrix_mode_wr == matrix_mode_in);
  assign w_cmd_ok      = w_cmd_any & ~w_cmd_blocked;
  assign w_do_pop      = w_cmd_ok & pop;
  assign w_do_push     = w_cmd_ok & ~pop & push;
  assign w_do_li       = w_cmd_ok & ~pop & ~push & load_identity;

  assign w_mv_full    = (r_depth_mv == MV_FULL);
  assign w_mv_empty   = (r_depth_mv == PTR_ZERO);
  assign w_proj_full  = (r_depth_proj == PROJ_FULL);
  assign w_proj_empty = (r_depth_proj == PTR_ZERO);

  assign w_mv_push_ok   = w_do_push & ~matrix_mode_in & ~w_mv_full;
  assign w_mv_pop_ok    = w_do_pop  & ~matrix_mode_in & ~w_mv_empty;
  assign w_mv_li        = w_do_li   & ~matrix_mode_in;
  assign w_proj_push_ok = w_do_push & matrix_mode_in & ~w_proj_full;
  assign w_proj_pop_ok  = w_do_pop  & matrix_mode_in & ~w_proj_empty;
  assign w_proj_li      = w_do_li   & matrix_mode_in;

  assign w_ovf_set = w_do_push & (matrix_mode_in ? w_proj_full : w_mv_full);
  assign w_udf_set = w_do_pop  & (matrix_mode_in ? w_proj_empty : w_mv_empty);

  assign w_mv_wr_idx   = MV_AW'(r_depth_mv);
  assign w_mv_rd_idx   = MV_AW'(r_depth_mv - PTR_ONE);
  assign w_proj_wr_idx = PROJ_AW'(r_depth_proj);
  assign w_proj_rd_idx = PROJ_AW'(r_depth_proj - PTR_ONE);

  // Next modelview top and depth.
  always_comb begin
    w_mv_top_nxt   = r_top_mv;
    w_mv_depth_nxt = r_depth_mv;
    if (w_wr_mv) begin
      w_mv_top_nxt = w_wr_data;
    end else if (w_mv_pop_ok) begin
      w_mv_top_nxt = r_sav_mv[w_mv_rd_idx];
    end else if (w_mv_li) begin
      w_mv_top_nxt = IDENT;
    end else begin
      w_mv_top_nxt = r_top_mv;
    end
    if (w_mv_push_ok) begin
      w_mv_depth_nxt = r_depth_mv + PTR_ONE;
    end else if (w_mv_pop_ok) begin
      w_mv_depth_nxt = r_depth_mv - PTR_ONE;
    end else begin
      w_mv_depth_nxt = r_depth_mv;
    end
  end

  // Next projection top and depth.
  always_comb begin
    w_proj_top_nxt   = r_top_proj;
    w_proj_depth_nxt = r_depth_proj;
    if (w_wr_proj) begin
      w_proj_top_nxt = w_wr_data;
    end else if (w_proj_pop_ok) begin
      w_proj_top_nxt = r_sav_proj[w_proj_rd_idx];
    end else if (w_proj_li) begin
      w_proj_top_nxt = IDENT;
    end else begin
      w_proj_top_nxt = r_top_proj;
    end
    if (w_proj_push_ok) begin
      w_proj_depth_nxt = r_depth_proj + PTR_ONE;
    end else if (w_proj_pop_ok) begin
      w_proj_depth_nxt = r_depth_proj - PTR_ONE;
    end else begin
      w_proj_depth_nxt = r_depth_proj;
    end
  end

  // Tops, depths and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_top_mv      <= IDENT;
      r_top_proj    <= IDENT;
      r_depth_mv    <= PTR_ZERO;
      r_depth_proj  <= PTR_ZERO;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_cmd_dropped <= 1'b0;
    end else begin
      r_top_mv      <= w_mv_top_nxt;
      r_top_proj    <= w_proj_top_nxt;
      r_depth_mv    <= w_mv_depth_nxt;
      r_depth_proj  <= w_proj_depth_nxt;
      r_overflow    <= w_ovf_set | (r_overflow & ~err_clear);
      r_underflow   <= w_udf_set | (r_underflow & ~err_clear);
      r_cmd_dropped <= w_cmd_multi | w_cmd_blocked;
    end
  end

  // Saved entries keep their contents across reset; only a live push writes them.
  always_ff @(posedge clk) begin
    if (!rst && w_mv_push_ok) begin
      r_sav_mv[w_mv_wr_idx] <= r_top_mv;
    end
    if (!rst && w_proj_push_ok) begin
      r_sav_proj[w_proj_wr_idx] <= r_top_proj;
    end
  end

  // Peek mux follows matrix_mode_in with no cycle delay.
  always_comb begin
    w_peek = r_top_mv;
    if (matrix_mode_in) begin
      w_peek = r_top_proj;
    end else begin
      w_peek = r_top_mv;
    end
  end

  assign matrix_peek_0 = w_peek[511:384];
  assign matrix_peek_1 = w_peek[383:256];
  assign matrix_peek_2 = w_peek[255:128];
  assign matrix_peek_3 = w_peek[127:0];
  assign depth_mv      = r_depth_mv;
  assign depth_proj    = r_depth_proj;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;
  assign cmd_dropped   = r_cmd_dropped;

endmodule

// File: tb/tb_matrix_stack.sv
// Self-checking bench for matrix_stack: directed literal checks plus a
// randomized run compared every cycle against a queue-style stack model.
module tb_matrix_stack;

  localparam int PTR_W = 6;

  logic clk = 1'b0;
  logic rst, matrix_mode_in, push, pop, load_identity, matrix_write_en, matrix_mode_wr, err_clear;
  logic [127:0] matrix_write_in_0, matrix_write_in_1, matrix_write_in_2, matrix_write_in_3;
  logic [127:0] matrix_peek_0, matrix_peek_1, matrix_peek_2, matrix_peek_3;
  logic [PTR_W-1:0] depth_mv, depth_proj;
  logic overflow, underflow, cmd_dropped;

  matrix_stack #(.MV_DEPTH(32), .PROJ_DEPTH(2), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .matrix_mode_in(matrix_mode_in), .push(push), .pop(pop),
    .load_identity(load_identity), .matrix_write_en(matrix_write_en), .matrix_mode_wr(matrix_mode_wr),
    .matrix_write_in_0(matrix_write_in_0), .matrix_write_in_1(matrix_write_in_1),
    .matrix_write_in_2(matrix_write_in_2), .matrix_write_in_3(matrix_write_in_3),
    .matrix_peek_0(matrix_peek_0), .matrix_peek_1(matrix_peek_1),
    .matrix_peek_2(matrix_peek_2), .matrix_peek_3(matrix_peek_3),
    .depth_mv(depth_mv), .depth_proj(depth_proj), .overflow(overflow), .underflow(underflow),
    .cmd_dropped(cmd_dropped), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] ID = {32'h3F800000, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h3F800000, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h3F800000, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h3F800000};

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model state: index 0 = modelview, 1 = projection.
  logic [511:0] m_top [2];
  logic [511:0] m_sav [2][32];
  int  m_depth [2];
  int  m_cap [2] = '{32, 2};
  bit  m_of, m_uf, m_drop;
  int  m_ncmd, m_s;
  bit  m_of_set, m_uf_set;

  function automatic logic [127:0] row(input logic [511:0] m, input int i);
    return m[511-128*i -: 128];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_top[0] = ID; m_top[1] = ID;
      m_depth[0] = 0; m_depth[1] = 0;
      m_of = 1'b0; m_uf = 1'b0; m_drop = 1'b0;
    end else begin
      m_ncmd = int'(push) + int'(pop) + int'(load_identity);
      m_drop = 1'b0; m_of_set = 1'b0; m_uf_set = 1'b0;
      if (m_ncmd > 0) begin
        if (matrix_write_en && matrix_mode_wr == matrix_mode_in) begin
          m_drop = 1'b1;
        end else begin
          m_drop = (m_ncmd > 1);
          m_s = int'(matrix_mode_in);
          if (pop) begin
            if (m_depth[m_s] > 0) begin
              m_depth[m_s]--;
              m_top[m_s] = m_sav[m_s][m_depth[m_s]];
            end else m_uf_set = 1'b1;
          end else if (push) begin
            if (m_depth[m_s] < m_cap[m_s]) begin
              m_sav[m_s][m_depth[m_s]] = m_top[m_s];
              m_depth[m_s]++;
            end else m_of_set = 1'b1;
          end else begin
            m_top[m_s] = ID;
          end
        end
      end
      if (matrix_write_en)
        m_top[int'(matrix_mode_wr)] = {matrix_write_in_0, matrix_write_in_1, matrix_write_in_2, matrix_write_in_3};
      m_of = m_of_set | (m_of & ~err_clear);
      m_uf = m_uf_set | (m_uf & ~err_clear);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("peek0", matrix_peek_0, row(m_top[int'(matrix_mode_in)], 0));
      chk("peek1", matrix_peek_1, row(m_top[int'(matrix_mode_in)], 1));
      chk("peek2", matrix_peek_2, row(m_top[int'(matrix_mode_in)], 2));
      chk("peek3", matrix_peek_3, row(m_top[int'(matrix_mode_in)], 3));
      chk("depth_mv", 128'(depth_mv), 128'(m_depth[0]));
      chk("depth_proj", 128'(depth_proj), 128'(m_depth[1]));
      chk("overflow", 128'(overflow), 128'(m_of));
      chk("underflow", 128'(underflow), 128'(m_uf));
      chk("cmd_dropped", 128'(cmd_dropped), 128'(m_drop));
    end
  end

  task automatic idle();
    push = 1'b0; pop = 1'b0; load_identity = 1'b0;
    matrix_write_en = 1'b0; matrix_mode_wr = 1'b0; err_clear = 1'b0;
  endtask

  task automatic step(input logic md, input logic ps, input logic pp, input logic li,
                      input logic we, input logic mwr, input logic [511:0] wd, input logic ec);
    matrix_mode_in = md; push = ps; pop = pp; load_identity = li;
    matrix_write_en = we; matrix_mode_wr = mwr; err_clear = ec;
    {matrix_write_in_0, matrix_write_in_1, matrix_write_in_2, matrix_write_in_3} = wd;
    @(posedge clk); #2;
    idle();
  endtask

  logic [511:0] abcd, efgh, pq, rnd;
  logic [127:0] ra, re, rh, pr0;

  initial begin
    ra = {32{4'hA}};
    re = {32{4'hE}};
    rh = {32{4'h7}};
    pr0 = 128'h01234567_89ABCDEF_02468ACE_13579BDF;
    abcd = {ra, {32{4'hB}}, {32{4'hC}}, {32{4'hD}}};
    efgh = {re, {32{4'hF}}, {32{4'h5}}, rh};
    pq   = {pr0, {32{4'h1}}, {32{4'h2}}, {32{4'h3}}};
    matrix_write_in_0 = '0; matrix_write_in_1 = '0; matrix_write_in_2 = '0; matrix_write_in_3 = '0;
    matrix_mode_in = 1'b0;
    idle();
    rst = 1'b1; push = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; idle();
    check_en = 1'b1;

    chk("rst_mv_peek0", matrix_peek_0, 128'h3F800000_00000000_00000000_00000000);
    chk("rst_mv_peek3", matrix_peek_3, 128'h00000000_00000000_00000000_3F800000);
    matrix_mode_in = 1'b1; #1;
    chk("rst_pj_peek0", matrix_peek_0, 128'h3F800000_00000000_00000000_00000000);
    chk("rst_pj_peek3", matrix_peek_3, 128'h00000000_00000000_00000000_3F800000);
    chk("rst_depth_mv", 128'(depth_mv), 128'd0);
    chk("rst_depth_proj", 128'(depth_proj), 128'd0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("push_depth_mv", 128'(depth_mv), 128'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, abcd, 1'b0);
    chk("wr_peek0", matrix_peek_0, ra);
    chk("wr_peek3", matrix_peek_3, {32{4'hD}});
    chk("wr_depth_mv", 128'(depth_mv), 128'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("pop_peek0", matrix_peek_0, 128'h3F800000_00000000_00000000_00000000);
    chk("pop_depth_mv", 128'(depth_mv), 128'd0);

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("ovf_before", 128'(overflow), 128'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("ovf_set", 128'(overflow), 128'd1);
    chk("ovf_depth_proj", 128'(depth_proj), 128'd2);
    chk("ovf_depth_mv", 128'(depth_mv), 128'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("ovf_cleared", 128'(overflow), 128'd0);

    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("udf_set", 128'(underflow), 128'd1);
    chk("udf_top", matrix_peek_0, 128'h3F800000_00000000_00000000_00000000);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, efgh, 1'b0);
    chk("conf_peek0", matrix_peek_0, re);
    chk("conf_peek3", matrix_peek_3, rh);
    chk("conf_dropped", 128'(cmd_dropped), 128'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("conf_pulse_end", 128'(cmd_dropped), 128'd0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pq, 1'b0);
    chk("cross_depth_mv", 128'(depth_mv), 128'd1);
    chk("cross_dropped", 128'(cmd_dropped), 128'd0);
    matrix_mode_in = 1'b1; #1;
    chk("cross_pj_peek0", matrix_peek_0, pr0);

    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 16; k++) rnd[k*32 +: 32] = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      matrix_mode_in = 1'($urandom_range(0, 1));
      push = ($urandom_range(0, 99) < 30);
      pop = ($urandom_range(0, 99) < 20);
      load_identity = ($urandom_range(0, 99) < 10);
      matrix_write_en = ($urandom_range(0, 99) < 25);
      matrix_mode_wr = 1'($urandom_range(0, 1));
      err_clear = ($urandom_range(0, 99) < 5);
      {matrix_write_in_0, matrix_write_in_1, matrix_write_in_2, matrix_write_in_3} = rnd;
      @(posedge clk); #2;
      rst = 1'b0;
      if (($urandom_range(0, 3)) == 0) matrix_mode_in = ~matrix_mode_in;
    end

    idle();
    @(posedge clk); #2;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
